// File: rtl/complex_butterfly_pipe.sv
// Two-stage radix-2 complex butterfly (A+B, A-B) with valid/ready flow control,
// optional divide-by-2 scaling and a sticky overflow flag.
// Build option: define BUTTERFLY_SAT_EN to saturate overflowing results instead of wrapping.
module complex_butterfly_pipe #(
  parameter int DATA_FFT_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_FFT_SIZE-1:0] data_in0_i,
  input  logic [DATA_FFT_SIZE-1:0] data_in0_q,
  input  logic [DATA_FFT_SIZE-1:0] data_in1_i,
  input  logic [DATA_FFT_SIZE-1:0] data_in1_q,
  input  logic                     in_scale,
  input  logic                     in_last,
  output logic [DATA_FFT_SIZE-1:0] data_out0_i,
  output logic [DATA_FFT_SIZE-1:0] data_out0_q,
  output logic [DATA_FFT_SIZE-1:0] data_out1_i,
  output logic [DATA_FFT_SIZE-1:0] data_out1_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     ovf_flag,
  input  logic                     ovf_clr
);

  localparam int W = DATA_FFT_SIZE;

  logic         s1_valid;
  logic         s1_scale;
  logic         s1_last;
  logic [W:0]   s1_sum_i, s1_sum_q, s1_dif_i, s1_dif_q;

  logic         load1, load2, in_xfer;
  logic [W-1:0] fit_sum_i, fit_sum_q, fit_dif_i, fit_dif_q;
  logic         ovf_any;

  // Reduce a full-precision value to W bits; scaling is a floor shift and never overflows.
  function automatic logic [W-1:0] fit(input logic [W:0] v, input logic sc);
    logic [W-1:0] r;
    if (sc) begin
      r = v[W:1];
    end else if (v[W] != v[W-1]) begin
`ifdef BUTTERFLY_SAT_EN
      r = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
      r = v[W-1:0];
`endif
    end else begin
      r = v[W-1:0];
    end
    return r;
  endfunction

  function automatic logic ovf(input logic [W:0] v, input logic sc);
    return !sc && (v[W] != v[W-1]);
  endfunction

  always_comb begin
    load2    = !out_valid || out_ready;
    load1    = !s1_valid || load2;
    in_ready = !rst && (!s1_valid || !out_valid || out_ready);
    in_xfer  = in_valid && in_ready;

    fit_sum_i = fit(s1_sum_i, s1_scale);
    fit_sum_q = fit(s1_sum_q, s1_scale);
    fit_dif_i = fit(s1_dif_i, s1_scale);
    fit_dif_q = fit(s1_dif_q, s1_scale);
    ovf_any   = s1_valid && (ovf(s1_sum_i, s1_scale) || ovf(s1_sum_q, s1_scale) ||
                             ovf(s1_dif_i, s1_scale) || ovf(s1_dif_q, s1_scale));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum_i <= '0;
      s1_sum_q <= '0;
      s1_dif_i <= '0;
      s1_dif_q <= '0;
    end else if (load1) begin
      s1_valid <= in_xfer;
      s1_scale <= in_scale;
      s1_last  <= in_last;
      s1_sum_i <= {data_in0_i[W-1], data_in0_i} + {data_in1_i[W-1], data_in1_i};
      s1_sum_q <= {data_in0_q[W-1], data_in0_q} + {data_in1_q[W-1], data_in1_q};
      s1_dif_i <= {data_in0_i[W-1], data_in0_i} - {data_in1_i[W-1], data_in1_i};
      s1_dif_q <= {data_in0_q[W-1], data_in0_q} - {data_in1_q[W-1], data_in1_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      data_out0_i <= '0;
      data_out0_q <= '0;
      data_out1_i <= '0;
      data_out1_q <= '0;
    end else if (load2) begin
      out_valid   <= s1_valid;
      out_last    <= s1_valid && s1_last;
      data_out0_i <= fit_sum_i;
      data_out0_q <= fit_sum_q;
      data_out1_i <= fit_dif_i;
      data_out1_q <= fit_dif_q;
    end
  end

  // Set takes priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (load2 && ovf_any) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_butterfly_pipe.sv
// Directed self-checking bench for complex_butterfly_pipe (W=16).
module tb_complex_butterfly_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_in0_i, data_in0_q, data_in1_i, data_in1_q;
  logic         in_scale;
  logic         in_last;
  logic [W-1:0] data_out0_i, data_out0_q, data_out1_i, data_out1_q;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         ovf_flag;
  logic         ovf_clr;

  int n_assert = 0;
  int n_fail   = 0;

  complex_butterfly_pipe #(.DATA_FFT_SIZE(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in0_i(data_in0_i), .data_in0_q(data_in0_q),
    .data_in1_i(data_in1_i), .data_in1_q(data_in1_q),
    .in_scale(in_scale), .in_last(in_last),
    .data_out0_i(data_out0_i), .data_out0_q(data_out0_q),
    .data_out1_i(data_out1_i), .data_out1_q(data_out1_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ai, input int aq, input int bi, input int bq,
                       input logic sc, input logic lst);
    in_valid   = 1'b1;
    data_in0_i = W'(ai);
    data_in0_q = W'(aq);
    data_in1_i = W'(bi);
    data_in1_q = W'(bq);
    in_scale   = sc;
    in_last    = lst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  tx, rx;
    bit  saw_stall, in_fire, out_fire;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_ovf", 16'(ovf_flag), 16'd0);
    chk("rst_out0_i", data_out0_i, 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(in_ready), 16'd1);
    out_ready = 1'b1;

    // Plain beat
    drive(100, -50, 20, 30, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("plain_valid", 16'(out_valid), 16'd1);
    chk("plain_sum_i", data_out0_i, 16'd120);
    chk("plain_sum_q", data_out0_q, 16'(-20));
    chk("plain_dif_i", data_out1_i, 16'd80);
    chk("plain_dif_q", data_out1_q, 16'(-80));
    step();
    chk("plain_ovf", 16'(ovf_flag), 16'd0);
    chk("plain_drain", 16'(out_valid), 16'd0);

    // Overflow, then clear
    drive(16'h7FFF, 0, 1, 0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("ovf_valid", 16'(out_valid), 16'd1);
`ifdef BUTTERFLY_SAT_EN
    chk("ovf_sum_i", data_out0_i, 16'h7FFF);
`else
    chk("ovf_sum_i", data_out0_i, 16'h8000);
`endif
    chk("ovf_dif_i", data_out1_i, 16'h7FFE);
    step();
    chk("ovf_flag_set", 16'(ovf_flag), 16'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_flag_clr", 16'(ovf_flag), 16'd0);

    // Scaling
    drive(16'h7FFF, -3, 16'h7FFF, 0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("scl_sum_i", data_out0_i, 16'h7FFF);
    chk("scl_sum_q", data_out0_q, 16'(-2));
    chk("scl_dif_i", data_out1_i, 16'd0);
    chk("scl_dif_q", data_out1_q, 16'(-2));
    step();
    chk("scl_ovf", 16'(ovf_flag), 16'd0);

    // Set and clear in the same cycle: set wins
    drive(0, 16'h8000, 0, 1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("setclr_flag", 16'(ovf_flag), 16'd1);
    step();
    chk("setclr_flag_hold", 16'(ovf_flag), 16'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("setclr_cleared", 16'(ovf_flag), 16'd0);

    // Backpressure stream of 8 beats
    tx = 0; rx = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (tx < 8) drive(10 * tx, -tx, tx, 2 * tx, 1'b0, tx == 7);
      else in_valid = 1'b0;
      #1;
      if (tx < 8 && !in_ready) saw_stall = 1'b1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        chk($sformatf("bp_sum_i_%0d", rx), data_out0_i, 16'(11 * rx));
        chk($sformatf("bp_dif_q_%0d", rx), data_out1_q, 16'(-3 * rx));
        chk($sformatf("bp_last_%0d", rx), 16'(out_last), 16'(rx == 7));
        rx++;
      end
      if (in_fire) tx++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_rx_count", 16'(rx), 16'd8);
    chk("bp_stall_seen", 16'(saw_stall), 16'd1);
    step();
    chk("bp_no_dup", 16'(out_valid), 16'd0);

    // Reset with two beats in flight
    drive(1, 1, 1, 1, 1'b0, 1'b0);
    step();
    drive(2, 2, 2, 2, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("mid_pre_valid", 16'(out_valid), 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 16'(in_ready), 16'd0);
    step();
    chk("mid_out_valid", 16'(out_valid), 16'd0);
    chk("mid_out_last", 16'(out_last), 16'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_in_ready", 16'(in_ready), 16'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid_no_stale_%0d", k), 16'(out_valid), 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
